// File: rtl/uart2wb_gen_if.sv
// rtl/uart2wb_gen_if.sv - Wishbone signal bundle between the UART bridge and the interconnect
interface uart2wb_gen_if #(
    parameter int AW = 24,
    parameter int DW = 8
);
    logic          i_wb_ack;
    logic [DW-1:0] i_wb_dat;
    logic [DW-1:0] o_wb_dat;
    logic          o_wb_stb;
    logic          o_wb_cyc;
    logic [AW-1:0] o_wb_addr;
    logic          o_wb_rw;

    modport master (
        input  i_wb_ack, i_wb_dat,
        output o_wb_dat, o_wb_stb, o_wb_cyc, o_wb_addr, o_wb_rw
    );
    modport slave (
        output i_wb_ack, i_wb_dat,
        input  o_wb_dat, o_wb_stb, o_wb_cyc, o_wb_addr, o_wb_rw
    );
endinterface

// File: rtl/uart2wb_gen.sv
// rtl/uart2wb_gen.sv - ASCII-hex command bridge from a byte UART to a Wishbone master
module uart2wb_gen #(
    parameter int AW      = 24,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    uart2wb_gen_if.master        wb,
    input  logic [7:0]           rx_dat,
    input  logic                 received,
    output logic [7:0]           tx_dat,
    output logic                 send,
    input  logic                 tx_busy
);
    localparam int ND = DW / 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_CNT, S_WB_WR, S_WB_RD, S_TX_HEX, S_TX_RSP
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdat;
    logic [DW-1:0] r_rdat;
    logic          r_stb;
    logic          r_rw;
    logic [3:0]    r_digits;
    logic [3:0]    r_cnt;
    logic [8:0]    r_beats;
    logic [15:0]   r_tmo;
    logic [3:0]    r_idx;
    logic [7:0]    r_rsp;
    logic          r_send_q;

    logic       w_is_hex;
    logic [3:0] w_nib;
    logic       w_abort;
    logic [3:0] w_tx_nib;
    logic [7:0] w_hex_chr;
    logic [7:0] w_tx_byte;
    logic       w_tx_req;
    logic       w_send;

    always_comb begin
        w_is_hex = 1'b1;
        w_nib    = 4'h0;
        if (rx_dat >= 8'h30 && rx_dat <= 8'h39)
            w_nib = rx_dat[3:0];
        else if ((rx_dat >= 8'h41 && rx_dat <= 8'h46) || (rx_dat >= 8'h61 && rx_dat <= 8'h66))
            w_nib = rx_dat[3:0] + 4'd9;
        else
            w_is_hex = 1'b0;
    end

    assign w_abort   = received && (rx_dat == 8'h2E);
    assign w_tx_nib  = r_rdat[DW-1 -: 4];
    assign w_hex_chr = (w_tx_nib < 4'd10) ? 8'h30 + {4'h0, w_tx_nib} : 8'h37 + {4'h0, w_tx_nib};
    assign w_tx_byte = (r_state == S_TX_RSP) ? r_rsp :
                       (r_idx == 4'(ND))     ? 8'h0A : w_hex_chr;
    assign w_tx_req  = (r_state == S_TX_HEX) || (r_state == S_TX_RSP);
    // Gated combinationally on the live tx_busy so a strobe never lands on a busy transmitter.
    assign w_send    = w_tx_req && !tx_busy && !r_send_q && !w_abort;
    assign send      = w_send;
    assign tx_dat    = w_send ? w_tx_byte : 8'h00;

    assign wb.o_wb_stb  = r_stb;
    assign wb.o_wb_cyc  = r_stb;
    assign wb.o_wb_addr = r_addr;
    assign wb.o_wb_dat  = r_wdat;
    assign wb.o_wb_rw   = r_rw;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdat   <= '0;
            r_rdat   <= '0;
            r_stb    <= 1'b0;
            r_rw     <= 1'b1;
            r_digits <= 4'd0;
            r_cnt    <= 4'd0;
            r_beats  <= 9'd0;
            r_tmo    <= 16'd0;
            r_idx    <= 4'd0;
            r_rsp    <= 8'h00;
            r_send_q <= 1'b0;
        end else begin
            r_send_q <= w_send;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_stb   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_ADDR: begin
                        if (received) begin
                            if (w_is_hex) begin
                                if (r_state == S_ADDR)
                                    r_addr <= (r_addr << 4) | AW'(w_nib);
                            end else begin
                                case (rx_dat)
                                    8'h70: r_state <= S_ADDR;
                                    8'h77: begin
                                        r_state  <= S_DATA;
                                        r_digits <= 4'd0;
                                    end
                                    8'h72: begin
                                        r_beats <= 9'd1;
                                        r_state <= S_WB_RD;
                                        r_stb   <= 1'b1;
                                        r_rw    <= 1'b1;
                                        r_tmo   <= 16'd0;
                                    end
                                    8'h52: begin
                                        r_state  <= S_CNT;
                                        r_digits <= 4'd0;
                                    end
                                    default: r_state <= S_IDLE;
                                endcase
                            end
                        end
                    end
                    S_DATA: begin
                        if (received) begin
                            if (w_is_hex) begin
                                r_wdat <= (r_wdat << 4) | DW'(w_nib);
                                if (r_digits == 4'(ND - 1)) begin
                                    r_state <= S_WB_WR;
                                    r_stb   <= 1'b1;
                                    r_rw    <= 1'b0;
                                    r_tmo   <= 16'd0;
                                end else begin
                                    r_digits <= r_digits + 4'd1;
                                end
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_CNT: begin
                        if (received) begin
                            if (!w_is_hex) begin
                                r_state <= S_IDLE;
                            end else if (r_digits == 4'd0) begin
                                r_cnt    <= w_nib;
                                r_digits <= 4'd1;
                            end else begin
                                r_beats <= {1'b0, r_cnt, w_nib} + 9'd1;
                                r_state <= S_WB_RD;
                                r_stb   <= 1'b1;
                                r_rw    <= 1'b1;
                                r_tmo   <= 16'd0;
                            end
                        end
                    end
                    S_WB_WR, S_WB_RD: begin
                        if (wb.i_wb_ack) begin
                            r_stb  <= 1'b0;
                            r_addr <= r_addr + AW'(1);
                            if (r_state == S_WB_RD) begin
                                r_rdat  <= wb.i_wb_dat;
                                r_idx   <= 4'd0;
                                r_state <= S_TX_HEX;
                            end else begin
                                r_rsp   <= 8'h4B;
                                r_state <= S_TX_RSP;
                            end
                        end else if (r_tmo == 16'(TIMEOUT - 1)) begin
                            r_stb   <= 1'b0;
                            r_beats <= 9'd0;
                            r_rsp   <= 8'h21;
                            r_state <= S_TX_RSP;
                        end else begin
                            r_tmo <= r_tmo + 16'd1;
                        end
                    end
                    S_TX_HEX: begin
                        if (w_send) begin
                            if (r_idx == 4'(ND)) begin
                                if (r_beats > 9'd1) begin
                                    r_beats <= r_beats - 9'd1;
                                    r_state <= S_WB_RD;
                                    r_stb   <= 1'b1;
                                    r_rw    <= 1'b1;
                                    r_tmo   <= 16'd0;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_rdat <= r_rdat << 4;
                                r_idx  <= r_idx + 4'd1;
                            end
                        end
                    end
                    S_TX_RSP: begin
                        if (w_send)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart2wb_gen.sv
// tb/tb_uart2wb_gen.sv - directed self-checking bench for uart2wb_gen (DW=8/TIMEOUT=8 and DW=16)
module tb_uart2wb_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic       rcv_a = 1'b0, rcv_b = 1'b0;
    logic       busy_a = 1'b0, busy_b = 1'b0;
    logic [7:0] txd_a, txd_b;
    logic       snd_a, snd_b;

    always #5 clk = ~clk;

    uart2wb_gen_if #(.AW(24), .DW(8))  wa();
    uart2wb_gen_if #(.AW(24), .DW(16)) wbb();

    uart2wb_gen #(.AW(24), .DW(8), .TIMEOUT(8)) dut_a (
        .i_wb_clk(clk), .i_wb_rst(rst), .wb(wa),
        .rx_dat(rx_dat), .received(rcv_a),
        .tx_dat(txd_a), .send(snd_a), .tx_busy(busy_a)
    );
    uart2wb_gen #(.AW(24), .DW(16), .TIMEOUT(255)) dut_b (
        .i_wb_clk(clk), .i_wb_rst(rst), .wb(wbb),
        .rx_dat(rx_dat), .received(rcv_b),
        .tx_dat(txd_b), .send(snd_b), .tx_busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEADDEAD;
    endfunction

    // Slave A: acks after ack_dly_a extra cycles, logs each bus cycle and its stb length
    logic [31:0] log_addr[$], log_rw[$], log_wdat[$], log_len[$], tx_a[$], tx_b[$];
    logic [7:0]  rdq_a[$];
    bit          ack_en_a = 1'b1;
    int          ack_dly_a = 0;
    int          wait_a = 0;
    bit          prev_a = 1'b0;
    bit          psend_a = 1'b0;
    int          viol_a = 0;
    logic [31:0] addr_b = 32'h0;
    int          cyc_b = 0;

    always @(negedge clk) begin
        wa.i_wb_ack = 1'b0;
        if (rst) begin
            prev_a = 1'b0;
        end else if (wa.o_wb_stb) begin
            if (!prev_a) begin
                log_addr.push_back(32'(wa.o_wb_addr));
                log_rw.push_back(32'(wa.o_wb_rw));
                log_wdat.push_back(32'(wa.o_wb_dat));
                wait_a = 0;
            end
            if (ack_en_a && wait_a == ack_dly_a) begin
                wa.i_wb_ack = 1'b1;
                if (rdq_a.size() > 0) wa.i_wb_dat = rdq_a.pop_front();
                else                  wa.i_wb_dat = 8'h00;
            end
            wait_a++;
        end else if (prev_a) begin
            log_len.push_back(32'(wait_a));
        end
        prev_a = wa.o_wb_stb && !rst;

        if (!rst) begin
            if (snd_a) begin
                tx_a.push_back(32'(txd_a));
                if (busy_a || psend_a) viol_a++;
            end else if (txd_a != 8'h00) begin
                viol_a++;
            end
        end
        psend_a = snd_a;
    end

    always @(negedge clk) begin
        wbb.i_wb_ack = 1'b0;
        wbb.i_wb_dat = 16'hBEEF;
        if (!rst && wbb.o_wb_stb) begin
            wbb.i_wb_ack = 1'b1;
            addr_b = 32'(wbb.o_wb_addr);
            cyc_b++;
        end
        if (!rst && snd_b) tx_b.push_back(32'(txd_b));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        tick();
        rx_dat = b;
        rcv_a  = !sel;
        rcv_b  = sel;
        tick();
        rcv_a  = 1'b0;
        rcv_b  = 1'b0;
    endtask

    task automatic send_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
    endtask

    task automatic wait_tx(input bit sel, input int n);
        for (int i = 0; i < 3000; i++) begin
            if ((sel ? tx_b.size() : tx_a.size()) >= n) break;
            tick();
        end
        check(sel ? "tx_count_b" : "tx_count_a", 32'(sel ? tx_b.size() : tx_a.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_stb",  32'(wa.o_wb_stb), 32'h0);
        check("rst_cyc",  32'(wa.o_wb_cyc), 32'h0);
        check("rst_rw",   32'(wa.o_wb_rw), 32'h1);
        check("rst_addr", 32'(wa.o_wb_addr), 32'h0);
        check("rst_dat",  32'(wa.o_wb_dat), 32'h0);
        check("rst_send", 32'(snd_a), 32'h0);
        check("rst_txd",  32'(txd_a), 32'h0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1: single write, ack on the 4th strobe cycle
        ack_dly_a = 3;
        send_str(0, "p0012A4w5C");
        wait_tx(0, 1);
        check("t1_ncyc", 32'(log_addr.size()), 32'd1);
        check("t1_addr", qget(log_addr, 0), 32'h0012A4);
        check("t1_rw",   qget(log_rw, 0), 32'h0);
        check("t1_wdat", qget(log_wdat, 0), 32'h5C);
        check("t1_len",  qget(log_len, 0), 32'd4);
        check("t1_tx",   qget(tx_a, 0), 32'h4B);
        check("t1_addr_inc", 32'(wa.o_wb_addr), 32'h0012A5);

        // 2: DW=16 read on the second bridge
        send_str(1, "p10r");
        wait_tx(1, 5);
        check("t2_tx0", qget(tx_b, 0), 32'h42);
        check("t2_tx1", qget(tx_b, 1), 32'h45);
        check("t2_tx2", qget(tx_b, 2), 32'h45);
        check("t2_tx3", qget(tx_b, 3), 32'h46);
        check("t2_tx4", qget(tx_b, 4), 32'h0A);
        check("t2_raddr", addr_b, 32'h10);
        check("t2_ncyc", 32'(cyc_b), 32'd1);
        check("t2_addr", 32'(wbb.o_wb_addr), 32'h11);

        // 3: burst of 3 wrapping across the top of the address space
        ack_dly_a = 0;
        rdq_a.push_back(8'h10); rdq_a.push_back(8'h20); rdq_a.push_back(8'h30);
        send_str(0, "p00FFFFFFR02");
        wait_tx(0, 10);
        check("t3_ncyc", 32'(log_addr.size()), 32'd4);
        check("t3_a0", qget(log_addr, 1), 32'hFFFFFF);
        check("t3_a1", qget(log_addr, 2), 32'h000000);
        check("t3_a2", qget(log_addr, 3), 32'h000001);
        check("t3_rw", qget(log_rw, 3), 32'h1);
        begin
            logic [31:0] exp3 [9] = '{32'h31, 32'h30, 32'h0A, 32'h32, 32'h30, 32'h0A, 32'h33, 32'h30, 32'h0A};
            for (int i = 0; i < 9; i++) check($sformatf("t3_tx%0d", i), qget(tx_a, 1 + i), exp3[i]);
        end
        check("t3_addr", 32'(wa.o_wb_addr), 32'h000002);

        // 4: no ack -> timeout after 8 strobe cycles
        ack_en_a = 1'b0;
        check("t4_stb_pre", 32'(wa.o_wb_stb), 32'h0);
        send_byte(0, "r");
        check("t4_stb_lat", 32'(wa.o_wb_stb), 32'h1);
        wait_tx(0, 11);
        check("t4_len",  qget(log_len, 4), 32'd8);
        check("t4_tx",   qget(tx_a, 10), 32'h21);
        check("t4_addr", 32'(wa.o_wb_addr), 32'h000002);

        // ack landing on the expiring cycle wins over the timeout
        ack_en_a = 1'b1;
        ack_dly_a = 7;
        send_str(0, "w11");
        wait_tx(0, 12);
        check("tw_len",  qget(log_len, 5), 32'd8);
        check("tw_tx",   qget(tx_a, 11), 32'h4B);
        check("tw_addr", 32'(wa.o_wb_addr), 32'h000003);

        // 5: abort discards partial write, lowercase hex, invalid byte in ADDR
        ack_dly_a = 0;
        send_str(0, "w3.wab");
        wait_tx(0, 13);
        check("t5_ncyc", 32'(log_addr.size()), 32'd7);
        check("t5_wdat", qget(log_wdat, 6), 32'hAB);
        check("t5_waddr", qget(log_addr, 6), 32'h000003);
        check("t5_tx",   qget(tx_a, 12), 32'h4B);
        send_str(0, "p12x5");
        repeat (3) tick();
        check("t5_addr_inv", 32'(wa.o_wb_addr), 32'h000412);
        check("t5_ncyc2", 32'(log_addr.size()), 32'd7);

        // 6: transmitter held busy for 20 cycles during a read response
        rdq_a.push_back(8'hA7);
        busy_a = 1'b1;
        send_byte(0, "r");
        repeat (20) tick();
        check("t6_hold", 32'(tx_a.size()), 32'd13);
        busy_a = 1'b0;
        wait_tx(0, 16);
        check("t6_tx0", qget(tx_a, 13), 32'h41);
        check("t6_tx1", qget(tx_a, 14), 32'h37);
        check("t6_tx2", qget(tx_a, 15), 32'h0A);
        check("t6_raddr", qget(log_addr, 7), 32'h000412);
        check("tx_rules", 32'(viol_a), 32'd0);

        // asynchronous reset in the middle of a bus cycle
        ack_en_a = 1'b0;
        send_byte(0, "r");
        tick();
        check("t6_stb_up", 32'(wa.o_wb_stb), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_stb", 32'(wa.o_wb_stb), 32'h0);
        check("t6_rst_cyc", 32'(wa.o_wb_cyc), 32'h0);
        check("t6_rst_addr", 32'(wa.o_wb_addr), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart2wb_gen.md
Name: uart2wb_gen

Overview:
Parametrised ASCII-hex command bridge from a byte UART to a single-master Wishbone bus, for bring-up and debug access to the SoC from a host terminal.
- Generalises the 8-bit/24-bit bridge: configurable address and data widths, lowercase hex, burst reads.
- Adds write acknowledge, bus timeout with error report, abort, and TX backpressure via tx_busy.
- Sits between the uart rx/tx pair and the system Wishbone interconnect.

Parameters:
AW, 24, Wishbone address width in bits; multiple of 4, range 4..32.
DW, 8, Wishbone data width in bits; multiple of 4, range 4..32.
TIMEOUT, 255, max cycles o_wb_stb stays high without i_wb_ack before abort; range 1..65535.

Ports:
i_wb_clk  in  1  clock, all logic on rising edge
i_wb_rst  in  1  asynchronous active-high reset
i_wb_ack  in  1  Wishbone acknowledge
i_wb_dat  in  DW  Wishbone read data, valid with i_wb_ack
o_wb_dat  out  DW  Wishbone write data
o_wb_stb  out  1  Wishbone strobe
o_wb_cyc  out  1  Wishbone cycle, identical to o_wb_stb
o_wb_addr  out  AW  Wishbone word address
o_wb_rw  out  1  1 = read, 0 = write
rx_dat  in  8  received byte, valid when received=1
received  in  1  one-cycle strobe per received byte
tx_dat  out  8  byte to transmit, valid when send=1, else 0
send  out  1  one-cycle transmit strobe
tx_busy  in  1  transmitter busy; no send while high

Behaviour:
- Reset (async): o_wb_stb/o_wb_cyc=0, o_wb_rw=1, o_wb_addr=0, o_wb_dat=0, tx_dat=0, send=0, state IDLE, beat counter 0. Reset mid-bus-cycle drops stb immediately.
- Byte decode:
  - '0'-'9', 'A'-'F', 'a'-'f' map to nibbles.
  - '.'=abort, 'p'=set addr, 'w'=write, 'r'=read, 'R'=burst read.
  - Any other byte is invalid.
- '.' in any state: go to IDLE, drop stb, discard partial data and pending TX. o_wb_addr is kept.
- States: IDLE, ADDR, DATA, CNT, WB_WR, WB_RD, TX_HEX, TX_RSP.
- IDLE:
  - 'p' -> ADDR.
  - 'w' -> DATA, digit count cleared.
  - 'r' -> WB_RD with beats=1.
  - 'R' -> CNT.
  - Other bytes ignored.
- ADDR: each hex digit does o_wb_addr <= {o_wb_addr[AW-5:0], nibble}; the last AW/4 digits win. 'w'/'r'/'R' act as in IDLE. Invalid -> IDLE, address keeps digits already shifted in.
- DATA:
  - Collect exactly DW/4 hex digits, MSB first, into o_wb_dat.
  - Any non-hex byte before completion -> IDLE, no bus cycle.
  - On the final digit -> WB_WR; o_wb_stb=1, o_wb_rw=0 on the next cycle.
- CNT: two hex digits N (MSB first) -> WB_RD with beats=N+1 (1..256). Non-hex -> IDLE.
- WB_RD: o_wb_stb=1, o_wb_rw=1 from the cycle after the command byte's received cycle. On ack:
  - stb=0 in the following cycle.
  - Capture i_wb_dat.
  - o_wb_addr+1.
  - -> TX_HEX.
- WB_WR: on ack, stb=0, o_wb_addr+1, queue 'K' (0x4B) -> TX_RSP.
- Timeout: a counter starts when stb rises. If it reaches TIMEOUT with no ack, stb=0, address unchanged, remaining burst cancelled, queue '!' (0x21) -> TX_RSP.
- TX_HEX:
  - Emit DW/4 digits of captured data, MSB nibble first, uppercase ('0'-'9', 'A'-'F'), then 0x0A.
  - If beats remain, decrement and return to WB_RD; else -> IDLE.
- TX_RSP: emit the queued byte, then -> IDLE.
- TX rules:
  - send asserts only in cycles with tx_busy=0 and send=0 in the previous cycle, so there is at least one idle cycle between strobes.
  - tx_dat is nonzero only when send=1.
- Received bytes in WB_RD/WB_WR/TX_HEX/TX_RSP: dropped, except '.'.
- Address arithmetic wraps modulo 2^AW: all-ones + 1 = 0.
- i_wb_ack while stb=0 is ignored.
- Ack in the same cycle the timeout expires: ack wins.

Test Plan:
1. Defaults; bytes "p0012A4w5C" -> one write cycle, addr 0x0012A4, dat 0x5C, rw=0; ack after 3 cycles -> send 'K', then o_wb_addr=0x0012A5.
2. DW=16; "p10r", slave returns 0xBEEF -> tx bytes 'B','E','E','F',0x0A in order; addr 0x11 after ack.
3. "p00FFFFFFR02", slave acks each with 0x10, 0x20, 0x30 -> three reads at 0xFFFFFF, 0x000000, 0x000001; tx "10\n20\n30\n".
4. TIMEOUT=8, slave never acks, "r" -> stb high exactly 8 cycles, then send '!'; address unchanged.
5. "w3" then "." then "wab" -> first write discarded; one write with dat 0xAB; invalid byte 'x' in ADDR returns to IDLE.
6. tx_busy held high 20 cycles during read response -> no send while high; digits resume in order, no loss; async reset mid-cycle clears stb within the same cycle.
